// File: rtl/simon_io_pkg.sv
// Shared constants, input FSM state type and beat-count helpers for the
// Simon 32/64 serial front end.
package simon_io_pkg;

  localparam int BLOCK_W = 32;
  localparam int KEY_W   = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEY  = 2'd1,
    S_PT   = 2'd2
  } in_state_e;

  // Number of bus beats needed to carry a 64-bit key.
  function automatic int key_beats(input int bus_w);
    return KEY_W / bus_w;
  endfunction

  // Number of bus beats needed to carry a 32-bit block.
  function automatic int blk_beats(input int bus_w);
    return BLOCK_W / bus_w;
  endfunction

endpackage

// File: rtl/simon_io_fifo.sv
// Small synchronous FIFO holding captured ciphertext blocks until they have
// been serialised out. Memory is not reset; only pointers and count are.
module simon_io_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    w_wr_nxt;
  logic [AW-1:0]    w_rd_nxt;

  assign w_wr_nxt = (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
  assign w_rd_nxt = (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
  assign o_head   = r_mem[r_rd];
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);

  // Storage write; data path needs no reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= w_wr_nxt;
      if (i_pop)  r_rd <= w_rd_nxt;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // A push into a full FIFO would silently drop a result; the upstream
  // credit gate is what keeps this from ever happening.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && o_full && !i_pop));

endmodule

// File: rtl/simon_serial_io.sv
// Narrow-bus serialising front end for the Simon 32/64 pipeline core:
// deserialises key/plaintext frames, tracks core latency with a valid shift
// register, buffers ciphertext and serialises it out under credit control.
// Optional feature macro: SIMON_IO_PARITY_EN (adds in_par/out_par/par_err).
module simon_serial_io
  import simon_io_pkg::*;
#(
  parameter int BUS_W     = 8,
  parameter int CORE_LAT  = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BUS_W-1:0]   in_data,
  input  logic               in_key,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BUS_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] core_plaintext,
  output logic [KEY_W-1:0]   core_keytext,
  input  logic [BLOCK_W-1:0] core_ciphertext,
  output logic               busy
`ifdef SIMON_IO_PARITY_EN
  ,
  input  logic               in_par,
  output logic               out_par,
  output logic               par_err
`endif
);

  localparam int KB    = key_beats(BUS_W);
  localparam int PB    = blk_beats(BUS_W);
  localparam int CNT_W = $clog2(KB + 1);
  localparam int CR_W  = $clog2(OUT_DEPTH + 1);
  localparam int OBW   = (PB > 1) ? $clog2(PB) : 1;

  in_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_idx;
  logic               r_gate_en;
  logic [CR_W-1:0]    r_credits;
  logic [CORE_LAT-1:0] r_vsr;
  logic [CORE_LAT:0]  w_vsr_nxt;
  logic [OBW-1:0]     r_obeat;
  logic [KEY_W-1:0]   r_key_stg, w_key_full, r_core_key;
  logic [BLOCK_W-1:0] r_pt_stg, w_pt_full, r_core_pt;
  logic               w_in_ready, w_acc, w_last, w_frame_key, w_first;
  logic               w_key_done, w_pt_done, w_reserve, w_release;
  logic               w_out_valid, w_out_fire, w_out_last;
  logic [BUS_W-1:0]   w_out_data;
  logic [BLOCK_W-1:0] w_fifo_head;
  logic               w_fifo_full, w_fifo_empty;

  // Reset-exit flop: holds in_ready low for the first cycle after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_gate_en <= 1'b0;
    else      r_gate_en <= 1'b1;
  end

  // Input FSM state and beat counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Input FSM next state, credit-gated in_ready and last-beat detection.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_in_ready  = 1'b0;
    w_frame_key = 1'b0;
    w_last      = 1'b0;
    w_idx       = r_cnt;
    w_first     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_idx       = '0;
        w_first     = 1'b1;
        w_frame_key = in_key;
        // A key may only replace the running key when nothing is in flight.
        w_in_ready  = r_gate_en && (r_credits < CR_W'(OUT_DEPTH)) &&
                      (!in_key || (r_credits == '0));
        w_last      = in_key ? (KB == 1) : (PB == 1);
        if (w_in_ready && in_valid && !w_last) begin
          w_state_nxt = in_key ? S_KEY : S_PT;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_KEY: begin
        w_frame_key = 1'b1;
        w_in_ready  = r_gate_en;
        w_last      = (r_cnt == CNT_W'(KB - 1));
        if (w_in_ready && in_valid) begin
          w_cnt_nxt   = w_last ? '0 : r_cnt + CNT_W'(1);
          w_state_nxt = w_last ? S_IDLE : S_KEY;
        end
      end
      S_PT: begin
        w_in_ready  = r_gate_en;
        w_last      = (r_cnt == CNT_W'(PB - 1));
        if (w_in_ready && in_valid) begin
          w_cnt_nxt   = w_last ? '0 : r_cnt + CNT_W'(1);
          w_state_nxt = w_last ? S_IDLE : S_PT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_acc      = w_in_ready && in_valid;
  assign w_key_done = w_acc && w_last && w_frame_key;
  assign w_pt_done  = w_acc && w_last && !w_frame_key;
  assign w_reserve  = w_acc && w_first && !in_key;
  assign in_ready   = w_in_ready;

  // Staging words with the current beat merged into its LSB-first slot.
  always_comb begin
    w_key_full = r_key_stg;
    w_pt_full  = r_pt_stg;
    for (int b = 0; b < KB; b++)
      if (w_idx == CNT_W'(b)) w_key_full[b*BUS_W +: BUS_W] = in_data;
    for (int b = 0; b < PB; b++)
      if (w_idx == CNT_W'(b)) w_pt_full[b*BUS_W +: BUS_W] = in_data;
  end

  // Staging registers; every slot is rewritten before it is used.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      if (w_frame_key) r_key_stg <= w_key_full;
      else             r_pt_stg  <= w_pt_full;
    end
  end

  // Core-facing words update only on a frame's last beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_core_key <= '0;
      r_core_pt  <= '0;
    end else begin
      if (w_key_done) r_core_key <= w_key_full;
      if (w_pt_done)  r_core_pt  <= w_pt_full;
    end
  end

  assign core_keytext   = r_core_key;
  assign core_plaintext = r_core_pt;

  // Credit counter: one per plaintext block from first input beat to last
  // output beat; simultaneous reserve and release cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_credits <= '0;
    else      r_credits <= r_credits + CR_W'(w_reserve) - CR_W'(w_release);
  end

  assign w_vsr_nxt = {r_vsr, w_pt_done};

  // Latency tracker standing in for the valid signal the core lacks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_vsr <= '0;
    else      r_vsr <= w_vsr_nxt[CORE_LAT-1:0];
  end

  simon_io_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (BLOCK_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (r_vsr[CORE_LAT-1]),
    .i_data  (core_ciphertext),
    .i_pop   (w_release),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_out_valid = !w_fifo_empty;
  assign w_out_fire  = w_out_valid && out_ready;
  assign w_out_last  = (r_obeat == OBW'(PB - 1));
  assign w_release   = w_out_fire && w_out_last;

  // Output beat selector; zero when nothing is buffered.
  always_comb begin
    w_out_data = '0;
    for (int b = 0; b < PB; b++)
      if (w_out_valid && (r_obeat == OBW'(b))) w_out_data = w_fifo_head[b*BUS_W +: BUS_W];
  end

  // Output beat position within the head block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_obeat <= '0;
    else if (w_out_fire) r_obeat <= w_out_last ? '0 : r_obeat + OBW'(1);
  end

  assign out_valid = w_out_valid;
  assign out_data  = w_out_data;
  assign busy      = (r_credits != '0) || (r_state != S_IDLE);

`ifdef SIMON_IO_PARITY_EN
  logic r_par_err;

  // Sticky parity error on any accepted beat; the beat is still used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_par_err <= 1'b0;
    else if (w_acc && ((^in_data) != in_par)) r_par_err <= 1'b1;
  end

  assign out_par = ^w_out_data;
  assign par_err = r_par_err;
`endif

endmodule

// File: tb/tb_simon_serial_io.sv
// Self-checking bench for simon_serial_io with a behavioural Simon 32/64
// core model and a scoreboard of expected ciphertext blocks.
module tb_simon_serial_io;

  localparam int BUS_W     = 8;
  localparam int CORE_LAT  = 32;
  localparam int OUT_DEPTH = 4;
  localparam int KB        = 64 / BUS_W;
  localparam int PB        = 32 / BUS_W;
  localparam int TIMEOUT   = 400;

  logic             clk;
  logic             rst;
  logic [BUS_W-1:0] in_data;
  logic             in_key;
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      core_plaintext;
  logic [63:0]      core_keytext;
  logic [31:0]      core_ciphertext;
  logic             busy;
`ifdef SIMON_IO_PARITY_EN
  logic             in_par;
  logic             out_par;
  logic             par_err;
  bit               inj_par;
`endif

  simon_serial_io #(
    .BUS_W     (BUS_W),
    .CORE_LAT  (CORE_LAT),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_key          (in_key),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .core_plaintext  (core_plaintext),
    .core_keytext    (core_keytext),
    .core_ciphertext (core_ciphertext),
    .busy            (busy)
`ifdef SIMON_IO_PARITY_EN
    ,
    .in_par          (in_par),
    .out_par         (out_par),
    .par_err         (par_err)
`endif
  );

  int          tests = 0;
  int          fails = 0;
  int          out_count = 0;
  logic [31:0] sb[$];
  logic [63:0] key_model = '0;
  logic [31:0] pt_model = '0;
  bit          rdy_mode = 0;
  bit          rdy_val = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
    return 16'((v << s) | (v >> (16 - s)));
  endfunction

  // Reference Simon 32/64 encryption (32 rounds).
  function automatic logic [31:0] simon_ref(input logic [63:0] key, input logic [31:0] pt);
    logic [15:0] k [32];
    logic [15:0] x, y, t;
    logic [61:0] z;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = 16'(key >> (16 * i));
    for (int i = 4; i < 32; i++) begin
      t = rol16(k[i-1], 13) ^ k[i-3];
      t = t ^ rol16(t, 15);
      k[i] = ~k[i-4] ^ t ^ {15'b0, z[61-(i-4)]} ^ 16'd3;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  // Core model: ciphertext of the inputs seen CORE_LAT-1 cycles earlier,
  // so a change at edge E is captured at edge E + CORE_LAT.
  logic [31:0] core_ct_now;
  logic [31:0] ct_dl [CORE_LAT];
  always_comb core_ct_now = simon_ref(core_keytext, core_plaintext);
  always @(posedge clk) begin
    ct_dl[0] <= core_ct_now;
    for (int i = 1; i < CORE_LAT; i++) ct_dl[i] <= ct_dl[i-1];
  end
  assign core_ciphertext = ct_dl[CORE_LAT-2];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // out_ready driver: held value or random per cycle.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Monitor: pops the scoreboard on each output frame and checks beats,
  // plus data holding under backpressure.
  initial begin : monitor
    logic [31:0]      cur;
    logic [BUS_W-1:0] exp_b;
    logic [BUS_W-1:0] prev_data;
    int               beat;
    bit               prev_stall;
    bit               have;
    cur = '0; beat = 0; prev_stall = 0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        beat = 0;
        prev_stall = 0;
      end else begin
        if (prev_stall)
          check(out_valid && (out_data == prev_data), "out_hold", {out_valid, out_data}, {1'b1, prev_data});
`ifdef SIMON_IO_PARITY_EN
        if (out_valid) check(out_par == ^out_data, "out_par", out_par, ^out_data);
`endif
        if (out_valid && out_ready) begin
          have = 1;
          if (beat == 0) begin
            if (sb.size() == 0) begin
              have = 0;
              tests++; fails++;
              $display("FAIL unexpected_output: got beat %0h, required no output", out_data);
            end else cur = sb.pop_front();
          end
          if (have) begin
            exp_b = BUS_W'(cur >> (beat * BUS_W));
            check(out_data == exp_b, "out_beat", out_data, exp_b);
            beat = (beat == PB - 1) ? 0 : beat + 1;
          end
          out_count++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  // Sends the first lim beats of a frame; a complete plaintext frame pushes
  // its expected ciphertext (or ovr_val) onto the scoreboard.
  task automatic send_frame(input bit is_key, input logic [63:0] data, input int lim,
                            input bit ovr, input logic [31:0] ovr_val, output int stalls);
    logic [63:0] d;
    int nb, n, waited;
    bit rdy, ok;
    d = data; nb = is_key ? KB : PB; n = (lim < nb) ? lim : nb;
    stalls = 0; ok = 1;
    for (int k = 0; k < n && ok; k++) begin
      in_valid = 1'b1;
      in_data  = d[BUS_W-1:0];
      in_key   = (k == 0) ? is_key : 1'($urandom_range(0, 1));
`ifdef SIMON_IO_PARITY_EN
      in_par   = (^d[BUS_W-1:0]) ^ (inj_par && (k == 0));
`endif
      waited = 0;
      forever begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        if (rdy) break;
        waited++; stalls++;
        if (waited >= TIMEOUT) begin ok = 0; break; end
      end
      #1;
      if (!ok) begin
        tests++; fails++;
        $display("FAIL beat_accept_timeout: in_ready low for %0d cycles, required a grant", waited);
      end else if (k < nb - 1) begin
        if (is_key) check(core_keytext == key_model, "key_atomic", core_keytext, key_model);
        else        check(core_plaintext == pt_model, "pt_atomic", core_plaintext, pt_model);
      end
      d = d >> BUS_W;
    end
    in_valid = 1'b0;
    in_key   = 1'b0;
`ifdef SIMON_IO_PARITY_EN
    inj_par  = 0;
`endif
    if (ok && lim >= nb) begin
      if (is_key) begin
        key_model = data;
        check(core_keytext == key_model, "keytext_load", core_keytext, key_model);
      end else begin
        pt_model = data[31:0];
        check(core_plaintext == pt_model, "pt_load", core_plaintext, pt_model);
        sb.push_back(ovr ? ovr_val : simon_ref(key_model, pt_model));
      end
    end
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while ((sb.size() != 0 || out_valid || busy) && c < 600) begin
      @(posedge clk); #1; c++;
    end
    check(c < 600, name, c, 600);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(in_ready == 0,        {tag, "_in_ready"},  in_ready, 0);
    check(out_valid == 0,       {tag, "_out_valid"}, out_valid, 0);
    check(out_data == 0,        {tag, "_out_data"},  out_data, 0);
    check(core_plaintext == 0,  {tag, "_core_pt"},   core_plaintext, 0);
    check(core_keytext == 0,    {tag, "_core_key"},  core_keytext, 0);
    check(busy == 0,            {tag, "_busy"},      busy, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check(in_ready == 0, "in_ready_after_release", in_ready, 0);
    @(negedge clk);
    check(in_ready == 1, "in_ready_rise", in_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int st, lat, stall, base;
    logic [63:0] k2;
    logic [31:0] p;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_key = 1'b0;
`ifdef SIMON_IO_PARITY_EN
    in_par = 1'b0; inj_par = 0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    release_reset();

    // Known answer with latency measurement.
    send_frame(1, 64'h1918111009080100, 64, 0, 0, st);
    send_frame(0, 64'h65656877, 64, 1, 32'hc69be9bb, st);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    check(lat == CORE_LAT, "kat_latency", lat, CORE_LAT);
    drain("kat_drain");

    // Back-to-back frames: no stall expected.
    stall = 0;
    for (int i = 0; i < 4; i++) begin
      send_frame(0, {32'b0, $urandom()}, 64, 0, 0, st);
      stall += st;
    end
    check(stall == 0, "b2b_no_stall", stall, 0);
    drain("b2b_drain");

    // Backpressure: fifth frame must wait for a credit.
    rdy_val = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_frame(0, {32'b0, $urandom()}, 64, 0, 0, st);
    p = $urandom();
    in_valid = 1'b1; in_key = 1'b0; in_data = p[BUS_W-1:0];
`ifdef SIMON_IO_PARITY_EN
    in_par = ^p[BUS_W-1:0];
`endif
    stall = 0;
    repeat (40) begin
      @(negedge clk);
      if (!in_ready) stall++;
      @(posedge clk); #1;
    end
    check(stall == 40, "bp_fifth_stalled", stall, 40);
    check(out_count == 0 || sb.size() == 4, "bp_no_pop", sb.size(), 4);
    rdy_val = 1;
    send_frame(0, {32'b0, p}, 64, 0, 0, st);
    check(st > 0, "bp_release_wait", st, 1);
    drain("bp_drain");

    // Key gating while one block is in flight.
    send_frame(0, {32'b0, $urandom()}, 64, 0, 0, st);
    k2 = {$urandom(), $urandom()};
    in_valid = 1'b1; in_key = 1'b1; in_data = k2[BUS_W-1:0];
`ifdef SIMON_IO_PARITY_EN
    in_par = ^k2[BUS_W-1:0];
`endif
    @(negedge clk);
    check(in_ready == 0, "key_gate_block", in_ready, 0);
    @(posedge clk); #1;
    send_frame(1, k2, 64, 0, 0, st);
    check(st > 0, "key_gate_wait", st, 1);
    check(sb.size() == 0, "key_after_flight", sb.size(), 0);
    send_frame(0, {32'b0, $urandom()}, 64, 0, 0, st);
    drain("keygate_drain");

    // Randomised traffic with random backpressure and occasional key swaps.
    rdy_mode = 1;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) send_frame(1, {$urandom(), $urandom()}, 64, 0, 0, st);
      else                           send_frame(0, {32'b0, $urandom()}, 64, 0, 0, st);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rdy_mode = 0; rdy_val = 1;
    @(posedge clk); #1;
    drain("random_drain");

`ifdef SIMON_IO_PARITY_EN
    check(par_err == 0, "par_err_clear", par_err, 0);
    inj_par = 1;
    send_frame(0, {32'b0, $urandom()}, 64, 0, 0, st);
    check(par_err == 1, "par_err_set", par_err, 1);
    send_frame(0, {32'b0, $urandom()}, 64, 0, 0, st);
    check(par_err == 1, "par_err_sticky", par_err, 1);
    drain("par_drain");
`endif

    // Reset mid-frame: partial plaintext discarded, nothing output.
    send_frame(0, {32'b0, $urandom()}, 2, 0, 0, st);
    check(busy == 1, "busy_partial", busy, 1);
    rst = 1'b0;
    key_model = '0; pt_model = '0;
    #1;
    check_reset_outputs("midrst");
`ifdef SIMON_IO_PARITY_EN
    check(par_err == 0, "par_err_reset", par_err, 0);
`endif
    repeat (3) @(posedge clk);
    release_reset();
    base = out_count;
    repeat (80) @(posedge clk);
    #1;
    check(out_count == base, "no_output_after_rst", out_count - base, 0);
    check(core_keytext == 0, "key_lost_after_rst", core_keytext, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
